// File: rtl/mdu32_if.sv
// mdu32_if: request/result bundle between the core pipeline and the mdu32
// multiply/divide unit.
//   Start  core -> mdu  request strobe, sampled on every rising edge
//   Op     core -> mdu  000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                       100 MTHI, 101 MTLO, 110/111 no-op
//   In_A   core -> mdu  rs operand (Rd_data_A)
//   In_B   core -> mdu  rt operand (Rd_data_B)
//   Busy   mdu -> core  iterative operation in flight
//   Done   mdu -> core  one-cycle pulse when HI/LO have been updated
//   Hi     mdu -> core  HI register
//   Lo     mdu -> core  LO register
interface mdu32_if;
   logic        Start;
   logic [2:0]  Op;
   logic [31:0] In_A;
   logic [31:0] In_B;
   logic        Busy;
   logic        Done;
   logic [31:0] Hi;
   logic [31:0] Lo;

   modport master (
      output Start, Op, In_A, In_B,
      input  Busy, Done, Hi, Lo
   );

   modport slave (
      input  Start, Op, In_A, In_B,
      output Busy, Done, Hi, Lo
   );
endinterface

// File: rtl/mdu32.sv
// mdu32: iterative multiply/divide unit with private HI/LO registers.
// Executes MULT/MULTU (32 shift-add steps), DIV/DIVU (32 restoring steps),
// MTHI/MTLO (single edge) and treats ops 110/111 as no-ops.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  mdu32_if.slave: Start/Op/In_A/In_B in, Busy/Done/Hi/Lo out
// Build option:
//   MDU_FAST_MULT_EN  when defined, MULT/MULTU use a single-cycle 32x32
//                     multiplier (IDLE -> FIX, latency 1); division stays
//                     iterative in both builds.
module mdu32 (
   input  logic   clk,
   input  logic   rst,
   mdu32_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX
   } state_t;

   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101,
      OP_NOP6  = 3'b110,
      OP_NOP7  = 3'b111
   } op_t;

   // Control state
   state_t      state;
   logic [4:0]  cnt;
   logic        is_div;
   logic        neg_lo;     // negate product / quotient in FIX
   logic        neg_hi;     // negate remainder in FIX
   logic        div_zero;
   logic        busy_q;
   logic        done_q;

   // Datapath state
   logic [63:0] acc;        // product accumulator
   logic [63:0] mcand;      // multiplicand, shifted left each step
   logic [31:0] mplier;     // multiplier, shifted right each step
   logic [31:0] rem;        // partial remainder
   logic [31:0] quo;        // dividend shifting out, quotient shifting in
   logic [31:0] divisor;
   logic [31:0] a_raw;      // unmodified rs, returned in HI on divide by zero
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   // Combinational helpers
   op_t         op;
   logic        is_signed;
   logic        a_neg;
   logic        b_neg;
   logic        accept;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [32:0] div_shift;
   logic [32:0] div_diff;
   logic        div_ge;
   logic [63:0] mul_raw;
   logic [63:0] mul_res;
   logic [31:0] quo_res;
   logic [31:0] rem_res;

   always_comb begin
      op        = op_t'(bus.Op);
      is_signed = (op == OP_MULT) || (op == OP_DIV);
      a_neg     = bus.In_A[31];
      b_neg     = bus.In_B[31];
      a_mag     = a_neg ? (~bus.In_A + 32'd1) : bus.In_A;
      b_mag     = b_neg ? (~bus.In_B + 32'd1) : bus.In_B;
      op_a      = is_signed ? a_mag : bus.In_A;
      op_b      = is_signed ? b_mag : bus.In_B;

      // FIX is the last busy cycle; a request arriving on its closing edge
      // is accepted so back-to-back operations lose no cycle.
      accept    = bus.Start && ((state == S_IDLE) || (state == S_FIX));

      // One restoring step: shift in the next dividend bit, subtract if it fits.
      div_shift = {rem, quo[31]};
      div_diff  = div_shift - {1'b0, divisor};
      div_ge    = (div_shift >= {1'b0, divisor});

`ifdef MDU_FAST_MULT_EN
      mul_raw   = {32'd0, mcand[31:0]} * {32'd0, mplier};
`else
      mul_raw   = acc;
`endif
      mul_res   = neg_lo ? (~mul_raw + 64'd1) : mul_raw;
      quo_res   = neg_lo ? (~quo + 32'd1) : quo;
      rem_res   = neg_hi ? (~rem + 32'd1) : rem;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_lo   <= 1'b0;
         neg_hi   <= 1'b0;
         div_zero <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         rem      <= '0;
         quo      <= '0;
         divisor  <= '0;
         a_raw    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         done_q <= 1'b0;

         case (state)
            S_MUL: begin
               if (mplier[0]) begin
                  acc <= acc + mcand;
               end
               mcand  <= {mcand[62:0], 1'b0};
               mplier <= {1'b0, mplier[31:1]};
               cnt    <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  state <= S_FIX;
               end
            end

            S_DIV: begin
               rem <= div_ge ? div_diff[31:0] : div_shift[31:0];
               quo <= {quo[30:0], div_ge};
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  state <= S_FIX;
               end
            end

            S_FIX: begin
               if (is_div) begin
                  if (div_zero) begin
                     hi_q <= a_raw;
                     lo_q <= '1;
                  end else begin
                     hi_q <= rem_res;
                     lo_q <= quo_res;
                  end
               end else begin
                  hi_q <= mul_res[63:32];
                  lo_q <= mul_res[31:0];
               end
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end

            default: begin
            end
         endcase

         // Placed after the state case so that an accept on the FIX edge
         // overrides the FIX bookkeeping; an MTHI/MTLO there is the younger
         // instruction and wins its register.
         if (accept) begin
            case (op)
               OP_MULT, OP_MULTU: begin
                  acc    <= '0;
                  mcand  <= {32'd0, op_a};
                  mplier <= op_b;
                  neg_lo <= is_signed && (a_neg ^ b_neg);
                  neg_hi <= 1'b0;
                  is_div <= 1'b0;
                  cnt    <= '0;
                  busy_q <= 1'b1;
`ifdef MDU_FAST_MULT_EN
                  state  <= S_FIX;
`else
                  state  <= S_MUL;
`endif
               end

               OP_DIV, OP_DIVU: begin
                  rem      <= '0;
                  quo      <= op_a;
                  divisor  <= op_b;
                  neg_lo   <= is_signed && (a_neg ^ b_neg);
                  neg_hi   <= is_signed && a_neg;
                  div_zero <= (bus.In_B == 32'd0);
                  a_raw    <= bus.In_A;
                  is_div   <= 1'b1;
                  cnt      <= '0;
                  busy_q   <= 1'b1;
                  state    <= S_DIV;
               end

               OP_MTHI: begin
                  hi_q   <= bus.In_A;
                  done_q <= 1'b1;
               end

               OP_MTLO: begin
                  lo_q   <= bus.In_A;
                  done_q <= 1'b1;
               end

               default: begin
               end
            endcase
         end
      end
   end

   assign bus.Busy = busy_q;
   assign bus.Done = done_q;
   assign bus.Hi   = hi_q;
   assign bus.Lo   = lo_q;

endmodule
